exe_stage_mc: RTL and testbench
===============================

Name: exe_stage_mc

Overview:
- Parametrised execute stage that sits between the ID/EXE and EXE/MEM boundaries of the pipeline.
- Selects operands from N forwarding sources, runs single-cycle ALU ops or an iterative multi-cycle multiply, and resolves branches.
- Results are held in an internal output register with a valid/ready handshake, so the stage can stall upstream and be stalled downstream.
- Adds a flush input and a busy indication for the hazard unit.

Parameters:
- DATA_W, 32, datapath width.
- FWD_SRCS, 2, number of forwarding sources; source 1 is MEM and source 2 is WB.
- SEL_W, $clog2(FWD_SRCS+1), width of each operand selector.
- MUL_CYCLES, 4, multiply latency in cycles. DATA_W must be divisible by MUL_CYCLES.
- BR_SHIFT, 2, left shift applied to the branch offset.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous reset, active-low.
- flush  in  1  kills any accepted or in-flight op.
- in_valid  in  1  upstream op present.
- in_ready  out  1  stage can accept an op this cycle.
- exe_cmd  in  4  ALU command.
- branch_type  in  2  branch condition.
- pc  in  DATA_W  PC+1 of the op.
- val1, val2, src2_val  in  DATA_W  register-file operands; val2 also carries the branch offset.
- val1_sel, val2_sel, src2_sel  in  SEL_W  forwarding selects.
- fwd_data  in  FWD_SRCS*DATA_W  forwarding buses; slice k-1 is source k.
- out_valid  out  1  result register holds a valid op.
- out_ready  in  1  downstream accepts the result.
- alu_result  out  DATA_W  registered ALU or multiply result.
- src2_val_out  out  DATA_W  registered forwarded store data.
- branch_address  out  DATA_W  registered pc + (op2 << BR_SHIFT).
- branch_taken  out  1  registered; meaningful only while out_valid=1.
- busy  out  1  high while the FSM is in MUL.

Behaviour:
- Reset (rst=0 at a clock edge): out_valid, branch_taken, busy, alu_result, src2_val_out and branch_address go to 0; FSM goes to IDLE.
- Operand select:
  - sel=0 selects the local operand.
  - sel=k with 1<=k<=FWD_SRCS selects fwd_data slice k-1.
  - sel>FWD_SRCS selects the local operand.
  - Forwarded values are sampled only in the accept cycle.
- Accept condition: in_valid && in_ready && !flush.
- in_ready = (state==IDLE) && (!out_valid || out_ready).
- ALU commands, result width DATA_W, wrap-around, no flags:
  - 0000 ADD, 0010 SUB, 0100 AND, 0101 OR, 0110 NOR, 0111 XOR.
  - 1000 SLL, 1001 SRA, 1010 SRL; shift amount is op2[$clog2(DATA_W)-1:0].
  - 1100 MUL (multi-cycle).
  - Any other code gives result 0.
- Branch types, evaluated on the forwarded operands:
  - 00 never taken.
  - 01 taken if op1==0.
  - 10 taken if op1!=src2.
  - 11 always taken.
  - branch_address is always computed and registered, regardless of branch_type.
- FSM states: IDLE, MUL.
  - IDLE, accept of a non-MUL op: on the next edge the result register loads and out_valid=1. Latency is 1 cycle.
  - IDLE, accept of MUL: operands are latched, state goes to MUL, counter=0, busy=1.
  - MUL: each cycle a shift-add step processes DATA_W/MUL_CYCLES multiplier bits.
  - When counter==MUL_CYCLES-1, the low DATA_W bits of the product load the result register, out_valid=1, and the FSM returns to IDLE. From accept to out_valid is MUL_CYCLES cycles.
  - branch_taken=0 for MUL.
- Result register handshake:
  - Holds its value while out_valid && !out_ready; outputs are stable while stalled.
  - Clears out_valid when out_ready=1 and nothing new is loaded in the same cycle.
  - A simultaneous drain and load is allowed; this gives back-to-back throughput of 1 op per cycle.
- Flush:
  - A synchronous kill with priority over everything except reset.
  - out_valid→0, branch_taken→0, FSM→IDLE, busy→0.
  - An op presented in the same cycle is not accepted.
  - A MUL in flight is discarded; the counter resets.
- Reset mid-MUL: same effect as flush, and the data registers go to 0.
- in_ready is combinational from state, out_valid and out_ready; it does not depend on flush.

Decomposition:
- Package exe_pkg holds:
  - exe_cmd localparams (CMD_ADD…CMD_MUL).
  - branch_type localparams (BR_NONE, BR_EQZ, BR_NE, BR_JMP).
  - FSM state enum.
- One sub-module: exe_mul_iter, the iterative shift-add multiplier.
  - Ports: start, operands, done, product.
  - Parametrised by DATA_W and MUL_CYCLES.
- Operand muxes and the ALU stay inline.

Test Plan:
- ADD with val1=5, val2=7, sels 0, out_ready=1 → one cycle later out_valid=1, alu_result=12. Back-to-back SUB 3-5 → next cycle alu_result=0xFFFFFFFE.
- Forwarding: val1_sel=1 with slice0=0x100, val2_sel=2 with slice1=0x23, XOR → alu_result=0x123. Also drive val1_sel=3 → the local val1 is used.
- MUL 0x1234×0x10 with MUL_CYCLES=4 → in_ready=0 and busy=1 for 4 cycles, then alu_result=0x12340, in_ready=1. 0xFFFFFFFF×2 → 0xFFFFFFFE (wrap).
- Branch BR_NE with op1=3, src2 forwarded=3 → branch_taken=0. With src2=4 → branch_taken=1, and pc=0x40, val2=5 gives branch_address=0x54.
- Backpressure: hold out_ready=0 after an ADD → out_valid and alu_result stay stable and in_ready=0. Raise out_ready together with a new op → drain and load occur in the same edge.
- Flush two cycles into a MUL → out_valid stays 0, busy=0 next cycle. A subsequent ADD 1+1 gives 2. Also assert rst=0 mid-MUL → all outputs 0 on the next edge.

Source files
------------

// File: rtl/exe_pkg.sv
// Shared encodings for the execute stage: ALU commands, branch conditions, FSM states.
package exe_pkg;

  localparam logic [3:0] CMD_ADD = 4'b0000;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_AND = 4'b0100;
  localparam logic [3:0] CMD_OR  = 4'b0101;
  localparam logic [3:0] CMD_NOR = 4'b0110;
  localparam logic [3:0] CMD_XOR = 4'b0111;
  localparam logic [3:0] CMD_SLL = 4'b1000;
  localparam logic [3:0] CMD_SRA = 4'b1001;
  localparam logic [3:0] CMD_SRL = 4'b1010;
  localparam logic [3:0] CMD_MUL = 4'b1100;

  localparam logic [1:0] BR_NONE = 2'b00;
  localparam logic [1:0] BR_EQZ  = 2'b01;
  localparam logic [1:0] BR_NE   = 2'b10;
  localparam logic [1:0] BR_JMP  = 2'b11;

  typedef enum logic {ST_IDLE, ST_MUL} exe_state_e;

endpackage

// File: rtl/exe_mul_iter.sv
// Iterative shift-add multiplier; retires DATA_W/MUL_CYCLES multiplier bits per step.
module exe_mul_iter #(
  parameter int DATA_W     = 32,
  parameter int MUL_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              step,
  input  logic              clear,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              done,
  output logic [DATA_W-1:0] product
);
  localparam int STEP  = DATA_W / MUL_CYCLES;
  localparam int CNT_W = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;

  logic [DATA_W-1:0] mcand_q, mplier_q, acc_q, acc_d, partial;
  logic [CNT_W-1:0]  cnt_q;

  always_comb begin
    partial = '0;
    for (int j = 0; j < STEP; j++)
      if (mplier_q[j]) partial = partial + (mcand_q << j);
    acc_d = acc_q + partial;
  end

  // product is the accumulator including the current step, so the final step needs no extra cycle
  assign done    = step && (cnt_q == CNT_W'(MUL_CYCLES - 1));
  assign product = acc_d;

  always_ff @(posedge clk) begin
    if (!rst) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (start) begin
      mcand_q  <= a;
      mplier_q <= b;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else if (step) begin
      mcand_q  <= mcand_q << STEP;
      mplier_q <= mplier_q >> STEP;
      acc_q    <= acc_d;
      cnt_q    <= done ? '0 : cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/exe_stage_mc.sv
// Execute stage: operand forwarding, single-cycle ALU, iterative multiply, branch resolve,
// all feeding one valid/ready output register.
module exe_stage_mc
  import exe_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int FWD_SRCS   = 2,
  parameter int SEL_W      = $clog2(FWD_SRCS + 1),
  parameter int MUL_CYCLES = 4,
  parameter int BR_SHIFT   = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [3:0]                 exe_cmd,
  input  logic [1:0]                 branch_type,
  input  logic [DATA_W-1:0]          pc,
  input  logic [DATA_W-1:0]          val1,
  input  logic [DATA_W-1:0]          val2,
  input  logic [DATA_W-1:0]          src2_val,
  input  logic [SEL_W-1:0]           val1_sel,
  input  logic [SEL_W-1:0]           val2_sel,
  input  logic [SEL_W-1:0]           src2_sel,
  input  logic [FWD_SRCS*DATA_W-1:0] fwd_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_W-1:0]          alu_result,
  output logic [DATA_W-1:0]          src2_val_out,
  output logic [DATA_W-1:0]          branch_address,
  output logic                       branch_taken,
  output logic                       busy
);
  localparam int SH_W = $clog2(DATA_W);

  exe_state_e state_q, state_d;
  logic [FWD_SRCS-1:0][DATA_W-1:0] fwd;
  logic [DATA_W-1:0] op1, op2, src2, alu_res, br_addr, mul_prod;
  logic [SH_W-1:0]   shamt;
  logic accept, is_mul, load_alu, load_mul, mul_done, br_cond;

  assign fwd = fwd_data;

  // selects outside 1..FWD_SRCS fall back to the register-file value
  always_comb begin
    op1  = val1;
    op2  = val2;
    src2 = src2_val;
    for (int k = 1; k <= FWD_SRCS; k++) begin
      if (val1_sel == SEL_W'(k)) op1  = fwd[k-1];
      if (val2_sel == SEL_W'(k)) op2  = fwd[k-1];
      if (src2_sel == SEL_W'(k)) src2 = fwd[k-1];
    end
  end

  assign shamt = op2[SH_W-1:0];

  always_comb begin
    alu_res = '0;
    case (exe_cmd)
      CMD_ADD: alu_res = op1 + op2;
      CMD_SUB: alu_res = op1 - op2;
      CMD_AND: alu_res = op1 & op2;
      CMD_OR:  alu_res = op1 | op2;
      CMD_NOR: alu_res = ~(op1 | op2);
      CMD_XOR: alu_res = op1 ^ op2;
      CMD_SLL: alu_res = op1 << shamt;
      CMD_SRA: alu_res = $signed(op1) >>> shamt;
      CMD_SRL: alu_res = op1 >> shamt;
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    br_cond = 1'b0;
    case (branch_type)
      BR_EQZ:  br_cond = (op1 == '0);
      BR_NE:   br_cond = (op1 != src2);
      BR_JMP:  br_cond = 1'b1;
      default: br_cond = 1'b0;
    endcase
  end

  assign br_addr  = pc + (op2 << BR_SHIFT);
  assign in_ready = (state_q == ST_IDLE) && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready && !flush;
  assign is_mul   = (exe_cmd == CMD_MUL);
  assign load_alu = accept && !is_mul;
  assign load_mul = (state_q == ST_MUL) && mul_done && !flush;
  assign busy     = (state_q == ST_MUL);

  exe_mul_iter #(.DATA_W(DATA_W), .MUL_CYCLES(MUL_CYCLES)) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (accept && is_mul),
    .step    (state_q == ST_MUL),
    .clear   (flush),
    .a       (op1),
    .b       (op2),
    .done    (mul_done),
    .product (mul_prod)
  );

  always_comb begin
    state_d = state_q;
    if (flush) state_d = ST_IDLE;
    else begin
      case (state_q)
        ST_IDLE: if (accept && is_mul) state_d = ST_MUL;
        ST_MUL:  if (mul_done) state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  // A MUL accept only happens once the register is free or draining this edge,
  // so its store data and branch address can go straight into the output register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      out_valid      <= 1'b0;
      branch_taken   <= 1'b0;
      alu_result     <= '0;
      src2_val_out   <= '0;
      branch_address <= '0;
    end else if (flush) begin
      out_valid    <= 1'b0;
      branch_taken <= 1'b0;
    end else if (load_alu) begin
      out_valid      <= 1'b1;
      alu_result     <= alu_res;
      src2_val_out   <= src2;
      branch_address <= br_addr;
      branch_taken   <= br_cond;
    end else if (load_mul) begin
      out_valid    <= 1'b1;
      alu_result   <= mul_prod;
      branch_taken <= 1'b0;
    end else begin
      if (accept) begin
        src2_val_out   <= src2;
        branch_address <= br_addr;
      end
      if (out_ready) out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_exe_stage_mc.sv
// Directed bench for exe_stage_mc with hand-computed expectations.
module tb_exe_stage_mc;
  import exe_pkg::*;

  localparam int DATA_W = 32;
  localparam int SEL_W  = 2;

  logic clk = 1'b0;
  logic rst, flush, in_valid, in_ready, out_valid, out_ready, branch_taken, busy;
  logic [3:0] exe_cmd;
  logic [1:0] branch_type;
  logic [DATA_W-1:0] pc, val1, val2, src2_val, alu_result, src2_val_out, branch_address;
  logic [SEL_W-1:0] val1_sel, val2_sel, src2_sel;
  logic [2*DATA_W-1:0] fwd_data;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  exe_stage_mc dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .exe_cmd(exe_cmd), .branch_type(branch_type), .pc(pc), .val1(val1), .val2(val2),
    .src2_val(src2_val), .val1_sel(val1_sel), .val2_sel(val2_sel), .src2_sel(src2_sel),
    .fwd_data(fwd_data), .out_valid(out_valid), .out_ready(out_ready),
    .alu_result(alu_result), .src2_val_out(src2_val_out), .branch_address(branch_address),
    .branch_taken(branch_taken), .busy(busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic op(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    exe_cmd = c; val1 = a; val2 = b; src2_val = '0; pc = '0;
    branch_type = BR_NONE; val1_sel = '0; val2_sel = '0; src2_sel = '0;
    in_valid = 1'b1;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_mul(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp);
    op(CMD_MUL, a, b);
    branch_type = BR_JMP;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk({tag, "_busy"}, 32'(busy), 32'd1);
      chk({tag, "_inrdy"}, 32'(in_ready), 32'd0);
      chk({tag, "_vld_lo"}, 32'(out_valid), 32'd0);
      tick();
    end
    chk({tag, "_vld"}, 32'(out_valid), 32'd1);
    chk({tag, "_res"}, alu_result, exp);
    chk({tag, "_busy_lo"}, 32'(busy), 32'd0);
    chk({tag, "_inrdy_hi"}, 32'(in_ready), 32'd1);
    chk({tag, "_taken"}, 32'(branch_taken), 32'd0);
  endtask

  initial begin
    rst = 1'b0; flush = 1'b0; out_ready = 1'b1; fwd_data = '0;
    op(CMD_ADD, 0, 0);
    in_valid = 1'b0;
    tick(); tick();
    chk("rst_vld", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_taken", 32'(branch_taken), 32'd0);
    chk("rst_res", alu_result, 32'd0);
    chk("rst_src2", src2_val_out, 32'd0);
    chk("rst_badr", branch_address, 32'd0);
    rst = 1'b1;

    // single-cycle ALU, back to back
    op(CMD_ADD, 5, 7);
    tick();
    chk("add_vld", 32'(out_valid), 32'd1);
    chk("add_res", alu_result, 32'd12);
    op(CMD_SUB, 3, 5);
    tick();
    chk("sub_res", alu_result, 32'hFFFF_FFFE);
    chk("sub_vld", 32'(out_valid), 32'd1);

    // forwarding
    op(CMD_XOR, 32'hFFFF, 32'hFFFF);
    val1_sel = 2'd1; val2_sel = 2'd2;
    fwd_data = {32'h23, 32'h100};
    tick();
    chk("fwd_xor", alu_result, 32'h123);
    op(CMD_XOR, 32'h5, 32'h3);
    val1_sel = 2'd3;
    tick();
    chk("fwd_sel3", alu_result, 32'h6);
    op(CMD_SRA, 32'h8000_0000, 32'd4);
    tick();
    chk("sra", alu_result, 32'hF800_0000);

    // branch resolve
    op(CMD_ADD, 3, 5);
    branch_type = BR_NE; src2_sel = 2'd1; src2_val = 32'd9; pc = 32'h40;
    fwd_data = {32'h0, 32'h3};
    tick();
    chk("bne_eq_taken", 32'(branch_taken), 32'd0);
    chk("bne_badr", branch_address, 32'h54);
    chk("bne_src2", src2_val_out, 32'h3);
    chk("bne_res", alu_result, 32'h8);
    op(CMD_ADD, 3, 5);
    branch_type = BR_NE; src2_sel = 2'd1; pc = 32'h40;
    fwd_data = {32'h0, 32'h4};
    tick();
    chk("bne_ne_taken", 32'(branch_taken), 32'd1);
    chk("bne_ne_badr", branch_address, 32'h54);

    // backpressure
    op(CMD_ADD, 10, 20);
    tick();
    out_ready = 1'b0;
    op(CMD_ADD, 1, 2);
    #1;
    chk("bp_inrdy", 32'(in_ready), 32'd0);
    tick();
    chk("bp_vld1", 32'(out_valid), 32'd1);
    chk("bp_res1", alu_result, 32'd30);
    tick();
    chk("bp_res2", alu_result, 32'd30);
    out_ready = 1'b1;
    tick();
    chk("bp_reload", alu_result, 32'd3);
    chk("bp_vld2", 32'(out_valid), 32'd1);
    in_valid = 1'b0;
    tick();
    chk("drain_vld", 32'(out_valid), 32'd0);

    // multiply
    do_mul("mul1", 32'h1234, 32'h10, 32'h12340);
    do_mul("mulwrap", 32'hFFFF_FFFF, 32'h2, 32'hFFFF_FFFE);
    tick();

    // flush two cycles into a MUL
    op(CMD_MUL, 7, 9);
    tick();
    in_valid = 1'b0;
    tick(); tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("fl_busy", 32'(busy), 32'd0);
    chk("fl_vld", 32'(out_valid), 32'd0);
    chk("fl_inrdy", 32'(in_ready), 32'd1);
    op(CMD_ADD, 9, 9);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("fl_noacc", 32'(out_valid), 32'd0);
    tick(); tick(); tick();
    chk("fl_killed", 32'(out_valid), 32'd0);
    op(CMD_ADD, 1, 1);
    tick();
    in_valid = 1'b0;
    chk("fl_add_vld", 32'(out_valid), 32'd1);
    chk("fl_add_res", alu_result, 32'd2);

    // reset mid-MUL
    op(CMD_MUL, 3, 3);
    pc = 32'h100;
    tick();
    in_valid = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    chk("rm_vld", 32'(out_valid), 32'd0);
    chk("rm_busy", 32'(busy), 32'd0);
    chk("rm_res", alu_result, 32'd0);
    chk("rm_badr", branch_address, 32'd0);
    rst = 1'b1;
    tick(); tick(); tick(); tick(); tick();
    chk("rm_after", 32'(out_valid), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
